// File: rtl/asip_decode_pkg.sv
// asip_decode_pkg
//   Shared types for the ASIP decode stage.
//   - opcode_e    : 4-bit opcode map (D..F are reserved and decode as illegal)
//   - wb_src_e    : write-back source select driven on write_reg_from
//   - decoded_t   : control bits produced by decode_lut for one opcode
//   - src_use_t   : which instruction fields are read, and from which file
package asip_decode_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_ADDI = 4'h3,
    OP_LDR  = 4'h4,
    OP_STR  = 4'h5,
    OP_VADD = 4'h6,
    OP_VSUB = 4'h7,
    OP_VLD  = 4'h8,
    OP_VST  = 4'h9,
    OP_MOVI = 4'hA,
    OP_JMP  = 4'hB,
    OP_BNZ  = 4'hC,
    OP_RSVD = 4'hD,
    OP_RSVE = 4'hE,
    OP_RSVF = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IMM = 2'b10
  } wb_src_e;

  typedef struct packed {
    logic [OPC_W-1:0] exec_op;
    wb_src_e          write_reg_from;
    logic             reg_write_en_sc;
    logic             reg_write_en_vec;
    logic             mem_write;
    logic             pc_write_en;
    logic             illegal;
  } decoded_t;

  // rd_sc covers ADDI, which reads its own destination as the first operand.
  typedef struct packed {
    logic rs1_sc;
    logic rs1_vec;
    logic rs2_sc;
    logic rs2_vec;
    logic rd_sc;
  } src_use_t;

endpackage

// File: rtl/decode_stage_pipe_lut.sv
// decode_lut
//   Purely combinational opcode decoder.
//   Ports:
//     opcode  in  4          : instruction opcode field
//     ctrl    out decoded_t  : control flags, exec_op and write-back source
//     src_use out src_use_t  : register fields read and which file they index
module decode_lut
  import asip_decode_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output decoded_t         ctrl,
  output src_use_t         src_use
);

  always_comb begin
    ctrl                = '0;
    ctrl.exec_op        = opcode;
    ctrl.write_reg_from = WB_ALU;
    src_use             = '0;

    unique case (opcode_e'(opcode))
      OP_NOP: ;
      OP_ADD, OP_SUB: begin
        ctrl.reg_write_en_sc = 1'b1;
        src_use.rs1_sc       = 1'b1;
        src_use.rs2_sc       = 1'b1;
      end
      OP_ADDI: begin
        ctrl.reg_write_en_sc = 1'b1;
        src_use.rd_sc        = 1'b1;
      end
      OP_LDR: begin
        ctrl.reg_write_en_sc = 1'b1;
        ctrl.write_reg_from  = WB_MEM;
        src_use.rs1_sc       = 1'b1;
      end
      OP_STR: begin
        ctrl.mem_write = 1'b1;
        src_use.rs1_sc = 1'b1;
        src_use.rs2_sc = 1'b1;
      end
      OP_VADD, OP_VSUB: begin
        ctrl.reg_write_en_vec = 1'b1;
        src_use.rs1_vec       = 1'b1;
        src_use.rs2_vec       = 1'b1;
      end
      OP_VLD: begin
        ctrl.reg_write_en_vec = 1'b1;
        ctrl.write_reg_from   = WB_MEM;
        src_use.rs1_sc        = 1'b1;
      end
      OP_VST: begin
        ctrl.mem_write  = 1'b1;
        src_use.rs1_sc  = 1'b1;
        src_use.rs2_vec = 1'b1;
      end
      OP_MOVI: begin
        ctrl.reg_write_en_sc = 1'b1;
        ctrl.write_reg_from  = WB_IMM;
      end
      OP_JMP: begin
        ctrl.pc_write_en = 1'b1;
      end
      OP_BNZ: begin
        ctrl.pc_write_en = 1'b1;
        src_use.rs1_sc   = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
//   Registered decode stage between fetch and execute. Decodes one instruction
//   per cycle, tracks in-flight register writes in a scalar and a vector
//   scoreboard, and stalls fetch on RAW/WAW hazards.
//   Ports:
//     clk, reset                      : clock, synchronous active-high reset
//     in_valid/in_ready, instruction  : fetch side handshake and word
//     flush                           : kill held output, refuse input
//     wb_valid, wb_is_vec, wb_reg     : writeback completion (clears scoreboard)
//     out_valid/out_ready             : execute side handshake
//     exec_op, reg_to_write, src_a, src_b, immediate, write_reg_from,
//     reg_write_en_sc, reg_write_en_vec, mem_write, pc_write_en, illegal
//                                     : registered decoded bundle
module decode_stage_pipe
  import asip_decode_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_W   = 4,
  parameter int IMM_W   = INSTR_W - 4 - REG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic               wb_is_vec,
  input  logic [REG_W-1:0]   wb_reg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         exec_op,
  output logic [REG_W-1:0]   reg_to_write,
  output logic [REG_W-1:0]   src_a,
  output logic [REG_W-1:0]   src_b,
  output logic [IMM_W-1:0]   immediate,
  output logic [1:0]         write_reg_from,
  output logic               reg_write_en_sc,
  output logic               reg_write_en_vec,
  output logic               mem_write,
  output logic               pc_write_en,
  output logic               illegal
);

  localparam int NREG   = 1 << REG_W;
  localparam int RD_HI  = INSTR_W - 1 - OPC_W;
  localparam int RS1_HI = RD_HI - REG_W;
  localparam int RS2_HI = RS1_HI - REG_W;

  logic [OPC_W-1:0] f_opcode;
  logic [REG_W-1:0] f_rd;
  logic [REG_W-1:0] f_rs1;
  logic [REG_W-1:0] f_rs2;
  logic [IMM_W-1:0] f_imm;

  assign f_opcode = instruction[INSTR_W-1 -: OPC_W];
  assign f_rd     = instruction[RD_HI  -: REG_W];
  assign f_rs1    = instruction[RS1_HI -: REG_W];
  assign f_rs2    = instruction[RS2_HI -: REG_W];
  assign f_imm    = instruction[IMM_W-1:0];

  decoded_t dec;
  src_use_t use_f;

  decode_lut u_decode_lut (
    .opcode  (f_opcode),
    .ctrl    (dec),
    .src_use (use_f)
  );

  logic [NREG-1:0] pend_sc;
  logic [NREG-1:0] pend_vec;

  logic [NREG-1:0] wb_onehot;
  logic [NREG-1:0] clr_wb_sc;
  logic [NREG-1:0] clr_wb_vec;
  logic [NREG-1:0] busy_sc;
  logic [NREG-1:0] busy_vec;
  logic [NREG-1:0] clr_kill_sc;
  logic [NREG-1:0] clr_kill_vec;
  logic [NREG-1:0] set_sc;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] rd_onehot;
  logic [NREG-1:0] held_onehot;

  logic raw;
  logic waw;
  logic hazard;
  logic load;
  logic kill;

  assign wb_onehot   = wb_valid ? (NREG'(1) << wb_reg) : '0;
  assign clr_wb_sc   = wb_is_vec ? '0 : wb_onehot;
  assign clr_wb_vec  = wb_is_vec ? wb_onehot : '0;
  assign rd_onehot   = NREG'(1) << f_rd;
  assign held_onehot = NREG'(1) << reg_to_write;

  // A writeback landing this cycle already frees its register for the hazard
  // check, so a dependent instruction is accepted in the same cycle.
  assign busy_sc  = pend_sc  & ~clr_wb_sc;
  assign busy_vec = pend_vec & ~clr_wb_vec;

  assign raw = (use_f.rs1_sc  & busy_sc[f_rs1])
             | (use_f.rs1_vec & busy_vec[f_rs1])
             | (use_f.rs2_sc  & busy_sc[f_rs2])
             | (use_f.rs2_vec & busy_vec[f_rs2])
             | (use_f.rd_sc   & busy_sc[f_rd]);

  assign waw = (dec.reg_write_en_sc  & busy_sc[f_rd])
             | (dec.reg_write_en_vec & busy_vec[f_rd]);

  assign hazard   = in_valid & (raw | waw);
  assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
  assign load     = in_valid & in_ready;

  // Only a valid held instruction has a scoreboard bit to give back.
  assign kill         = flush & out_valid;
  assign clr_kill_sc  = (kill & reg_write_en_sc)  ? held_onehot : '0;
  assign clr_kill_vec = (kill & reg_write_en_vec) ? held_onehot : '0;

  assign set_sc  = (load & dec.reg_write_en_sc)  ? rd_onehot : '0;
  assign set_vec = (load & dec.reg_write_en_vec) ? rd_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_sc  <= '0;
      pend_vec <= '0;
    end else begin
      // Set is OR-ed last so it wins over a same-cycle clear of the same bit.
      pend_sc  <= (busy_sc  & ~clr_kill_sc)  | set_sc;
      pend_vec <= (busy_vec & ~clr_kill_vec) | set_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid        <= 1'b0;
      exec_op          <= '0;
      reg_to_write     <= '0;
      src_a            <= '0;
      src_b            <= '0;
      immediate        <= '0;
      write_reg_from   <= WB_ALU;
      reg_write_en_sc  <= 1'b0;
      reg_write_en_vec <= 1'b0;
      mem_write        <= 1'b0;
      pc_write_en      <= 1'b0;
      illegal          <= 1'b0;
    end else if (load) begin
      out_valid        <= 1'b1;
      exec_op          <= dec.exec_op;
      reg_to_write     <= f_rd;
      src_a            <= f_rs1;
      src_b            <= f_rs2;
      immediate        <= f_imm;
      write_reg_from   <= dec.write_reg_from;
      reg_write_en_sc  <= dec.reg_write_en_sc;
      reg_write_en_vec <= dec.reg_write_en_vec;
      mem_write        <= dec.mem_write;
      pc_write_en      <= dec.pc_write_en;
      illegal          <= dec.illegal;
    end else if (flush || out_ready) begin
      // Bundle fields are left as-is; only the valid flag drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised, registered decode stage of the vectorial ASIP pipeline, between fetch and execute. It decodes one instruction per cycle into scalar and vector control fields, including `pc_write_en` and `exec_op`. It tracks in-flight register writes in a scoreboard and stalls fetch on RAW/WAW hazards. It uses a valid/ready handshake on both sides and supports a flush from branch resolution.

## Interface
Parameters:
- `INSTR_W`, 16: instruction width, ≥ 16.
- `REG_W`, 4: register-index field width; the scalar and vector files each hold 2^REG_W registers.
- `IMM_W`, `INSTR_W-4-REG_W`: immediate width.

Ports (one synchronous active-high reset `reset` on the single clock `clk`; the polarity and synchronicity are fixed):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: fetch holds an instruction.
- `in_ready` out 1: decode accepts this cycle.
- `instruction` in INSTR_W: instruction word.
- `flush` in 1: kill the held output and refuse input.
- `wb_valid` in 1: a writeback completes.
- `wb_is_vec` in 1: that writeback targets the vector file.
- `wb_reg` in REG_W: register written back.
- `out_valid` out 1: decoded bundle is valid.
- `out_ready` in 1: execute accepts.
- `exec_op` out 4: ALU/branch operation (the opcode).
- `reg_to_write`, `src_a`, `src_b` out REG_W each: rd, rs1, rs2.
- `immediate` out IMM_W: zero-extended immediate field.
- `write_reg_from` out 2: write-back source; 00 ALU, 01 memory, 10 immediate.
- `reg_write_en_sc`, `reg_write_en_vec`, `mem_write`, `pc_write_en`, `illegal` out 1 each: control flags.

## Operation
- Fields, counted from the MSB:
  - opcode: `[INSTR_W-1 -: 4]`.
  - rd: next REG_W bits.
  - rs1: next REG_W bits.
  - rs2: next REG_W bits.
  - imm: low IMM_W bits.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB: scalar, ALU source, sc write.
  - 3 ADDI: sc write, ALU source, uses rd as source.
  - 4 LDR: sc write, mem source, reads rs1.
  - 5 STR: `mem_write`, reads rs1 and rs2.
  - 6 VADD, 7 VSUB: vec write, ALU source, vector sources.
  - 8 VLD: vec write, mem source, scalar rs1 as address.
  - 9 VST: `mem_write`, vector rs2, scalar rs1 address.
  - A MOVI: sc write, imm source.
  - B JMP: `pc_write_en`.
  - C BNZ: `pc_write_en`, reads scalar rs1.
  - D–F: `illegal=1`, all enables 0.
- Scoreboard: two 2^REG_W bit vectors, `pend_sc` and `pend_vec`.
  - Set the rd bit when an instruction with a write enable loads the output register.
  - Clear the bit on `wb_valid`.
  - Same cycle, same bit, set and clear: set wins.
- Hazard: the incoming instruction reads a pending source of its file type, or writes a pending rd (WAW).
- `in_ready = (!out_valid | out_ready) & !hazard & !flush`.
- The output register loads on `in_valid & in_ready`. If the output empties without a load, `out_valid` drops to 0.
- `flush`:
  - `out_valid` goes to 0 next cycle.
  - The pend bit set by the killed instruction is cleared, unless that bit is also being cleared by `wb_valid` (idempotent).
  - A `wb_valid` in the same cycle still clears its own bit.
- Illegal opcodes pass through with `illegal=1` and do not touch the scoreboard.

## Timing
- Reset state:
  - `out_valid=0` and all scoreboard bits 0.
  - All registered outputs are 0, with `write_reg_from=00`.
  - `in_ready` is 1 when `in_valid` is present and `flush` is 0.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction/cycle with no hazards and `out_ready` held at 1.
- Outputs hold stable while `out_valid & !out_ready`.
- Hazard check uses the registered scoreboard plus the in-cycle clear by `wb_valid`. A writeback in cycle N unblocks a dependent instruction in cycle N.
- Reset asserted mid-stall returns to the reset state on the next edge.

## Structure
- Package `asip_decode_pkg`:
  - opcode enum.
  - `write_reg_from` codes.
  - `decoded_t` struct.
- One combinational sub-module, `decode_lut`: opcode → control bits and source-use flags.
- Scoreboard and handshake logic live in the top module.

## Test plan
- Reset, then ADDI 0x3A5F → next cycle:
  - `out_valid=1`, `exec_op=3`, `reg_to_write=A`, `immediate=5F`.
  - `reg_write_en_sc=1`, `write_reg_from=00`.
  - `pend_sc[A]=1`.
- ADDI 0x3A5F, then ADD 0x1BA2 → ADD is held (`in_ready=0`) until `wb_valid`, `wb_reg=A`, `wb_is_vec=0`. It is accepted in that same cycle.
- VADD 0x6123 while `out_ready=0` → outputs are stable for 3 cycles and `in_ready=0` throughout. The output drains when `out_ready=1`.
- JMP 0xB0FF followed by `flush` → `out_valid=0` next cycle, and `pend_*` is unchanged.
- LDR writing r4 is flushed while `out_valid=1` → `pend_sc[4]` returns to 0.
- 0xE000 → `illegal=1`, all enables 0, and no scoreboard change.
